// File: rtl/eu_pkg.sv
// -----------------------------------------------------------------------------
// eu_pkg -- shared definitions for the pipelined execution unit.
//   ALUOp encodings, R-type funct codes, the 4-bit ALU control enum and the
//   decoder that maps (ALUOp, funct) onto an ALU operation.
// -----------------------------------------------------------------------------
package eu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_MUL  = 4'b1000,
    ALU_NOR  = 4'b1100,
    ALU_NONE = 4'b1111    // unknown funct: result forced to zero
  } alu_ctrl_e;

  function automatic alu_ctrl_e alu_decode(input logic [1:0] aluop,
                                           input logic [5:0] funct);
    case (aluop)
      ALUOP_ADD: return ALU_ADD;
      ALUOP_SUB: return ALU_SUB;
      ALUOP_SLT: return ALU_SLT;
      default: begin
        case (funct)
          FUNCT_ADD:  return ALU_ADD;
          FUNCT_SUB:  return ALU_SUB;
          FUNCT_AND:  return ALU_AND;
          FUNCT_OR:   return ALU_OR;
          FUNCT_NOR:  return ALU_NOR;
          FUNCT_SLT:  return ALU_SLT;
          FUNCT_MULT: return ALU_MUL;
          default:    return ALU_NONE;
        endcase
      end
    endcase
  endfunction

endpackage

// File: rtl/eu_regfile.sv
// -----------------------------------------------------------------------------
// eu_regfile -- 2**NREG_LOG2 x DATA_W register file.
//   clk, reset      : clock, synchronous active-high reset (clears every entry)
//   ra_a_i/rd_a_o   : asynchronous read port A
//   ra_b_i/rd_b_o   : asynchronous read port B
//   we_i/wa_i/wd_i  : synchronous write port; writes to entry 0 are dropped
// -----------------------------------------------------------------------------
module eu_regfile #(
  parameter int DATA_W    = 32,
  parameter int NREG_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREG_LOG2-1:0] ra_a_i,
  output logic [DATA_W-1:0]    rd_a_o,
  input  logic [NREG_LOG2-1:0] ra_b_i,
  output logic [DATA_W-1:0]    rd_b_o,
  input  logic                 we_i,
  input  logic [NREG_LOG2-1:0] wa_i,
  input  logic [DATA_W-1:0]    wd_i
);

  localparam int NREG = 2 ** NREG_LOG2;

  logic [DATA_W-1:0] regs_q [NREG];

  // NOTE: the array is built from flops rather than a RAM macro precisely so
  // that every entry can be cleared by reset; a RAM could not be reset.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Entry 0 is never written and reset to zero, so it always reads zero.
  assign rd_a_o = regs_q[ra_a_i];
  assign rd_b_o = regs_q[ra_b_i];

endmodule

// File: rtl/cpu_eu_pipe.sv
// -----------------------------------------------------------------------------
// cpu_eu_pipe -- two-stage (EX, EX/WB) execution unit.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : instruction handshake (in_ready low only while busy)
//   RegDst, ALUSrc, RegWrite, MemtoReg, ALUOp, Instruction : decoded controls
//   SEImm                : sign-extended immediate of the presented instruction
//   RAM_Address, Data_to_Ram, Zero, out_valid : registered EX/WB stage outputs
//   Data_from_Ram        : RAM read data, used during the out_valid cycle
//   busy                 : iterative multiply in progress
// Optional feature: define CPU_EU_PIPE_MULT_EN to build the shift-add
// multiplier (funct 0x18); otherwise funct 0x18 yields 0 and busy is tied low.
// -----------------------------------------------------------------------------
module cpu_eu_pipe
  import eu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREG_LOG2 = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [1:0]        ALUOp,
  input  logic [25:0]       Instruction,
  output logic [DATA_W-1:0] SEImm,
  output logic [DATA_W-1:0] RAM_Address,
  output logic [DATA_W-1:0] Data_to_Ram,
  output logic              out_valid,
  input  logic [DATA_W-1:0] Data_from_Ram,
  output logic              Zero,
  output logic              busy
);

  logic [NREG_LOG2-1:0] rs_idx, rt_idx, rd_idx;
  logic [63:0]          imm_ext;
  assign rs_idx  = Instruction[21 +: NREG_LOG2];
  assign rt_idx  = Instruction[16 +: NREG_LOG2];
  assign rd_idx  = Instruction[11 +: NREG_LOG2];
  assign imm_ext = {{48{Instruction[15]}}, Instruction[15:0]};
  assign SEImm   = imm_ext[DATA_W-1:0];

  // EX/WB stage register
  logic                 wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]    wb_res_q, wb_res_d;
  logic [DATA_W-1:0]    wb_rt_q, wb_rt_d;
  logic                 wb_zero_q, wb_zero_d;
  logic                 wb_we_q, wb_we_d;
  logic                 wb_mem_q, wb_mem_d;
  logic [NREG_LOG2-1:0] wb_dst_q, wb_dst_d;

  logic [DATA_W-1:0] wb_wdata, rf_a, rf_b, rs_val, rt_val, alu_b, alu_res;
  logic              wb_fwd, accept;
  alu_ctrl_e         alu_ctrl;

  assign wb_wdata = wb_mem_q ? Data_from_Ram : wb_res_q;
  // Register 0 is never a forwarding source: its writes are discarded.
  assign wb_fwd   = wb_valid_q && wb_we_q && (wb_dst_q != '0);

  eu_regfile #(.DATA_W(DATA_W), .NREG_LOG2(NREG_LOG2)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .ra_a_i (rs_idx),
    .rd_a_o (rf_a),
    .ra_b_i (rt_idx),
    .rd_b_o (rf_b),
    .we_i   (wb_valid_q && wb_we_q),
    .wa_i   (wb_dst_q),
    .wd_i   (wb_wdata)
  );

  // The WB write lands at the same edge that accepts the next instruction,
  // so a matching read must see the in-flight write data instead.
  assign rs_val   = (wb_fwd && (wb_dst_q == rs_idx)) ? wb_wdata : rf_a;
  assign rt_val   = (wb_fwd && (wb_dst_q == rt_idx)) ? wb_wdata : rf_b;
  assign alu_b    = ALUSrc ? SEImm : rt_val;
  assign alu_ctrl = alu_decode(ALUOp, Instruction[5:0]);

  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_NOR: alu_res = ~(rs_val | alu_b);
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(rs_val) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  // Multiplier hand-off into the EX/WB stage
  logic                 is_mul, mul_done, mul_we;
  logic [DATA_W-1:0]    mul_res, mul_rt;
  logic [NREG_LOG2-1:0] mul_dst;

`ifdef CPU_EU_PIPE_MULT_EN
  localparam int CNT_W = $clog2(DATA_W);

  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_W-1:0]    mcand_q, mplier_q, acc_q, mrt_q, acc_step;
  logic [NREG_LOG2-1:0] mdst_q;
  logic                 mwe_q;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign is_mul   = (alu_ctrl == ALU_MUL);
  // The final shift-add step is folded into the cycle that hands off the
  // product, giving exactly DATA_W busy cycles.
  assign mul_done = busy_q && (cnt_q == '0);
  assign mul_res  = acc_step;
  assign mul_rt   = mrt_q;
  assign mul_dst  = mdst_q;
  assign mul_we   = mwe_q;
  assign busy     = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept && is_mul) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(DATA_W - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  // Operand/accumulator registers are qualified by busy_q and need no reset.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand_q  <= rs_val;
      mplier_q <= alu_b;
      acc_q    <= '0;
      mrt_q    <= rt_val;
      mdst_q   <= rd_idx;
      mwe_q    <= RegWrite;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_rt   = '0;
  assign mul_dst  = '0;
  assign mul_we   = 1'b0;
  assign busy     = 1'b0;
`endif

  assign in_ready = ~busy;
  assign accept   = in_valid && in_ready;

  // NOTE: every _d gets a default (bubble, hold outputs) before the branches
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_res_d   = wb_res_q;
    wb_rt_d    = wb_rt_q;
    wb_zero_d  = wb_zero_q;
    wb_we_d    = wb_we_q;
    wb_mem_d   = wb_mem_q;
    wb_dst_d   = wb_dst_q;
    if (mul_done) begin
      wb_valid_d = 1'b1;
      wb_res_d   = mul_res;
      wb_rt_d    = mul_rt;
      wb_zero_d  = (mul_res == '0);
      wb_we_d    = mul_we;
      wb_mem_d   = 1'b0;
      wb_dst_d   = mul_dst;
    end else if (accept && !is_mul) begin
      wb_valid_d = 1'b1;
      wb_res_d   = alu_res;
      wb_rt_d    = rt_val;
      wb_zero_d  = (alu_res == '0);
      wb_we_d    = RegWrite;
      wb_mem_d   = MemtoReg;
      wb_dst_d   = RegDst ? rd_idx : rt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_res_q   <= '0;
      wb_rt_q    <= '0;
      wb_zero_q  <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_mem_q   <= 1'b0;
      wb_dst_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_res_q   <= wb_res_d;
      wb_rt_q    <= wb_rt_d;
      wb_zero_q  <= wb_zero_d;
      wb_we_q    <= wb_we_d;
      wb_mem_q   <= wb_mem_d;
      wb_dst_q   <= wb_dst_d;
    end
  end

  assign out_valid   = wb_valid_q;
  assign RAM_Address = wb_res_q;
  assign Data_to_Ram = wb_rt_q;
  assign Zero        = wb_zero_q;

endmodule

// File: doc/cpu_eu_pipe.md
CPU_EU_PIPE -- requirements
Module: cpu_eu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath/register width (legal 8..64).
REQ-002 SHALL have parameter NREG_LOG2, default 5, register-file address width; register count = 2**NREG_LOG2 (legal 3..5).
REQ-003 SHALL have port clk, input, 1, the only clock; one clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, decoded instruction and controls present this cycle.
REQ-006 SHALL have port in_ready, output, 1, instruction accepted when in_valid and in_ready are both high.
REQ-007 SHALL have ports RegDst, ALUSrc, RegWrite, MemtoReg, input, 1 each; same meanings as the current single-cycle EU.
REQ-008 SHALL have port ALUOp, input, 2: 00 add, 01 sub, 10 decode funct, 11 slt.
REQ-009 SHALL have port Instruction, input, 26: rs [25:21], rt [20:16], rd [15:11], imm [15:0], funct [5:0]; register indices use low NREG_LOG2 bits.
REQ-010 SHALL have port SEImm, output, DATA_W, combinational sign-extended imm of the accepted instruction.
REQ-011 SHALL have ports RAM_Address and Data_to_Ram, output, DATA_W each, registered; ALU result and rt value of the EX/WB stage.
REQ-012 SHALL have port out_valid, output, 1, EX/WB stage holds a valid instruction.
REQ-013 SHALL have port Data_from_Ram, input, DATA_W, combinational RAM read data, sampled in the out_valid cycle.
REQ-014 SHALL have port Zero, output, 1, registered; high when the EX/WB ALU result is zero.
REQ-015 SHALL have port busy, output, 1, multi-cycle multiply in progress.

Function
REQ-016 SHALL be a 2-stage pipeline: EX (regfile read, forward, ALU) in the accept cycle; EX/WB register loaded at that edge; writeback at the following edge; latency 1 cycle to out_valid.
REQ-017 SHALL decode funct under ALUOp=10: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A signed slt; other funct codes give result 0.
REQ-018 SHALL use ALU B = SEImm when ALUSrc=1, else rt value; add/sub wrap modulo 2**DATA_W; slt result is 1 or 0 zero-extended.
REQ-019 SHALL write destination rd when RegDst=1 else rt, data Data_from_Ram when MemtoReg=1 else ALU result, only when out_valid and RegWrite.
REQ-020 SHALL keep register 0 reading as 0; writes to register 0 are discarded and never forwarded.
REQ-021 SHALL forward WB write data to rs and/or rt when the WB stage writes a matching non-zero register; forwarding overrides regfile contents, so back-to-back dependent instructions need no stall.
REQ-022 SHALL load a bubble (out_valid=0, no write, outputs hold value) when no instruction is accepted.
REQ-023 SHALL drive in_ready=1 except while busy=1.

Reset
REQ-024 SHALL on reset clear out_valid, Zero, busy, RAM_Address, Data_to_Ram and every register to 0, and drive in_ready=1 from the next cycle.
REQ-025 SHALL, on reset mid-multiply, abandon the multiply without writeback; reset outranks any simultaneous accept or writeback.

Configuration
REQ-026 SHALL compile an iterative multiplier only when macro CPU_EU_PIPE_MULT_EN is defined: ALUOp=10, funct 0x18 starts shift-add multiply, busy=1 and in_ready=0 for DATA_W cycles, then one out_valid cycle carrying low DATA_W product bits written to rd.
REQ-027 SHALL, without CPU_EU_PIPE_MULT_EN, treat funct 0x18 as unknown (result 0, single cycle) and tie busy to 0.

Structure
REQ-028 SHALL place ALUOp encodings, funct constants and the 4-bit ALU control enum in shared package eu_pkg.
REQ-029 SHALL instantiate one sub-module eu_regfile (parameterised DATA_W, NREG_LOG2; two async read ports, one sync write port, synchronous reset).

Verification
REQ-030 SHALL verify reset: assert reset 2 cycles mid-traffic -> all outputs 0, in_ready=1, every register reads 0.
REQ-031 SHALL verify forwarding: add r1=r0+imm 5, then add r2=r1+r1 next cycle -> r2=10, second out_valid RAM_Address=10.
REQ-032 SHALL verify memory path: sw with r3=0x100, imm 4 -> RAM_Address=0x104, Data_to_Ram=rt; lw with Data_from_Ram=0xDEADBEEF -> rt=0xDEADBEEF.
REQ-033 SHALL verify arithmetic edges: 0x7FFFFFFF+1 -> 0x80000000, Zero=0; sub 5-5 -> Zero=1; slt -1<1 -> 1; write to r0 -> r0 still 0.
REQ-034 SHALL verify with MULT_EN: 7*6 -> busy and in_ready=0 for 32 cycles, then rd=42; reset at cycle 10 -> no write, busy=0.
REQ-035 SHALL verify parameter sweep DATA_W=16, NREG_LOG2=3: 0xFFFF+1 -> 0, Zero=1; register index 9 aliases register 1.
